decoder38_pulse: RTL



---
 rtl/decoder38_pulse.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/decoder38_pulse.sv
// decoder38_pulse: sequential 3-to-8 decoder with pulse shaping.
// A code is accepted when gs & ei & ready. It is then driven on y as a one-hot
// pulse (1 << code) for HOLD cycles, followed by GAP cycles of y = 0.
// Up to two codes can wait in a FIFO while a pulse is in progress.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   ei       in   enable; gates code acceptance only
//   i[2:0]   in   code to decode
//   gs       in   code-valid strobe
//   ovf_clr  in   synchronous clear of ovf
//   ready    out  pending buffer not full
//   y[7:0]   out  registered one-hot output
//   busy     out  FSM in HOLD or GAP
//   eo       out  ei & ~busy & buffer empty
//   ovf      out  sticky flag: a valid code was dropped
module decoder38_pulse #(
    parameter int unsigned HOLD = 4,
    parameter int unsigned GAP  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ei,
    input  logic [2:0] i,
    input  logic       gs,
    input  logic       ovf_clr,
    output logic       ready,
    output logic [7:0] y,
    output logic       busy,
    output logic       eo,
    output logic       ovf
);

    localparam int unsigned MaxCnt = (HOLD > GAP) ? HOLD : GAP;
    localparam int unsigned CW     = $clog2(MaxCnt + 1);
    localparam logic [CW-1:0] HoldLd = CW'(HOLD - 1);
    localparam logic [CW-1:0] GapLd  = CW'((GAP > 0) ? GAP - 1 : 0);
    localparam bit HasGap = (GAP != 0);

    typedef enum logic [1:0] {StIdle, StHold, StGap} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      y_q, y_d;
    logic [2:0]      mem_q [2];
    logic            rd_ptr_q, wr_ptr_q;
    logic [1:0]      count_q, count_d;
    logic            ovf_q;

    logic            full, empty, accept, drop, push, pop, bypass;
    logic [2:0]      head;

    assign full   = (count_q == 2'd2);
    assign empty  = (count_q == 2'd0);
    assign accept = gs & ei & ~full;
    assign drop   = gs & ei & full;
    assign head   = mem_q[rd_ptr_q];

    // A bypassed code goes straight to y and never enters the FIFO.
    assign push    = accept & ~bypass;
    assign count_d = count_q + {1'b0, push} - {1'b0, pop};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        pop     = 1'b0;
        bypass  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    y_d     = 8'd1 << head;
                    cnt_d   = HoldLd;
                    state_d = StHold;
                end else if (accept) begin
                    bypass  = 1'b1;
                    y_d     = 8'd1 << i;
                    cnt_d   = HoldLd;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (HasGap) begin
                    y_d     = 8'h00;
                    cnt_d   = GapLd;
                    state_d = StGap;
                end else if (!empty) begin
                    // No gap: next pulse follows without a zero cycle.
                    pop   = 1'b1;
                    y_d   = 8'd1 << head;
                    cnt_d = HoldLd;
                end else begin
                    y_d     = 8'h00;
                    state_d = StIdle;
                end
            end
            StGap: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (!empty) begin
                    pop     = 1'b1;
                    y_d     = 8'd1 << head;
                    cnt_d   = HoldLd;
                    state_d = StHold;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                y_d     = 8'h00;
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            y_q      <= 8'h00;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            mem_q[0] <= 3'd0;
            mem_q[1] <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            count_q <= count_d;
            if (push) begin
                mem_q[wr_ptr_q] <= i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // Drop has priority over clear so a same-cycle loss is never hidden.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign ready = ~full;
    assign y     = y_q;
    assign busy  = (state_q != StIdle);
    assign eo    = ei & ~busy & empty;
    assign ovf   = ovf_q;

endmodule
